// File: rtl/dc_blocker_mc.sv
// dc_blocker_mc: multi-channel I/Q DC blocker with AXI-stream in/out and a
// settings bus. Each channel and each component keeps a leaky accumulator
// acc; the DC estimate is acc >>> shift, and it is subtracted from every
// sample while acc integrates the residual.
//
// Ports:
//   ce_clk, ce_rst               clock, asynchronous active-high reset
//   set_stb, set_addr, set_data  settings bus (SR_BASE: shift, SR_BASE+1: ctrl)
//   i_tdata/i_tlast/i_tvalid/i_tready  input stream, I in upper half, Q in lower
//   o_tdata/o_tlast/o_tvalid/o_tready  output stream, same packing
//
// ctrl bits: [0] bypass, [1] freeze accumulators, [2] clear (pulse, not stored).
// Pipeline: stage 1 captures x/tlast/dc and updates acc; stage 2 registers the
// saturated result. Both stages advance together when the output is free.
module dc_blocker_mc #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned SR_BASE   = 128,
    parameter int unsigned SHIFT_RST = 4
) (
    input  logic                 ce_clk,
    input  logic                 ce_rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [2*WIDTH-1:0]   i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [2*WIDTH-1:0]   o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready
);

    localparam int unsigned ACC_W  = WIDTH + 16;
    localparam int unsigned DIFF_W = ACC_W + 1;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Accumulator storage is rounded up to a power of two so ch_q indexes it
    // without a range check; entries at or above NUM_CH are never selected.
    localparam int unsigned ACC_N  = 1 << CH_W;
    localparam logic [7:0]  ADDR_SHIFT = 8'(SR_BASE);
    localparam logic [7:0]  ADDR_CTRL  = 8'(SR_BASE + 1);

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    logic       wr_shift_c;
    logic       wr_ctrl_c;
    logic       clear_c;
    logic [3:0] shift_q;
    logic       bypass_q;
    logic       freeze_q;
    logic       unused_set_data_c;

    assign wr_shift_c        = set_stb && (set_addr == ADDR_SHIFT);
    assign wr_ctrl_c         = set_stb && (set_addr == ADDR_CTRL);
    assign clear_c           = wr_ctrl_c && set_data[2];
    assign unused_set_data_c = ^set_data[31:4];

    // Shift of zero would make dc equal the raw accumulator; store it as 1.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            shift_q  <= 4'(SHIFT_RST);
            bypass_q <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            if (wr_shift_c) begin
                shift_q <= (set_data[3:0] == 4'd0) ? 4'd1 : set_data[3:0];
            end
            if (wr_ctrl_c) begin
                bypass_q <= set_data[0];
                freeze_q <= set_data[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic advance_c;
    logic accept_c;
    logic o_tvalid_q;

    assign advance_c = ~o_tvalid_q | o_tready;
    assign accept_c  = i_tvalid & advance_c;
    assign i_tready  = advance_c;

    // ------------------------------------------------------------------
    // Channel counter: wraps at NUM_CH, forced to 0 after a tlast sample
    // ------------------------------------------------------------------
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_d;

    always_comb begin
        ch_d = ch_q;
        if (accept_c) begin
            if (i_tlast || (ch_q == CH_W'(NUM_CH - 1))) begin
                ch_d = '0;
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    // ------------------------------------------------------------------
    // DC estimate and accumulator update for the current channel
    // Component index 0 is I (upper half), 1 is Q (lower half).
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_q     [ACC_N][2];
    logic        [WIDTH-1:0] in_comp_c [2];
    logic signed [ACC_W-1:0] acc_sel_c [2];
    logic signed [ACC_W-1:0] x_ext_c   [2];
    logic signed [ACC_W-1:0] dc_c      [2];
    logic signed [ACC_W-1:0] acc_d     [2];

    assign in_comp_c[0] = i_tdata[2*WIDTH-1:WIDTH];
    assign in_comp_c[1] = i_tdata[WIDTH-1:0];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            acc_sel_c[k] = acc_q[ch_q][k];
            x_ext_c[k]   = {{(ACC_W-WIDTH){in_comp_c[k][WIDTH-1]}}, in_comp_c[k]};
            dc_c[k]      = acc_sel_c[k] >>> shift_q;
            acc_d[k]     = acc_sel_c[k] + x_ext_c[k] - dc_c[k];
        end
    end

    // Clear beats a same-edge sample update; freeze holds every channel.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            for (int e = 0; e < ACC_N; e++) begin
                for (int k = 0; k < 2; k++) begin
                    acc_q[e][k] <= '0;
                end
            end
        end else if (clear_c) begin
            for (int e = 0; e < ACC_N; e++) begin
                for (int k = 0; k < 2; k++) begin
                    acc_q[e][k] <= '0;
                end
            end
        end else if (accept_c && !freeze_q) begin
            for (int k = 0; k < 2; k++) begin
                acc_q[ch_q][k] <= acc_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: sample, tlast, dc used for this sample, bypass at acceptance
    // ------------------------------------------------------------------
    logic                    s1_valid_q;
    logic [2*WIDTH-1:0]      s1_x_q;
    logic                    s1_last_q;
    logic                    s1_bypass_q;
    logic signed [ACC_W-1:0] s1_dc_q [2];

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_last_q   <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_dc_q[0]  <= '0;
            s1_dc_q[1]  <= '0;
        end else if (advance_c) begin
            s1_valid_q <= i_tvalid;
            if (i_tvalid) begin
                s1_x_q      <= i_tdata;
                s1_last_q   <= i_tlast;
                s1_bypass_q <= bypass_q;
                s1_dc_q[0]  <= dc_c[0];
                s1_dc_q[1]  <= dc_c[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: y = x - dc with saturation to WIDTH bits
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  s1_comp_c [2];
    logic [DIFF_W-1:0] diff_c    [2];
    logic [WIDTH-1:0]  y_c       [2];

    assign s1_comp_c[0] = s1_x_q[2*WIDTH-1:WIDTH];
    assign s1_comp_c[1] = s1_x_q[WIDTH-1:0];

    // The difference fits when every bit from the WIDTH-1 sign position up
    // is identical; otherwise clamp by the true sign.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            diff_c[k] = {{(DIFF_W-WIDTH){s1_comp_c[k][WIDTH-1]}}, s1_comp_c[k]}
                      - {s1_dc_q[k][ACC_W-1], s1_dc_q[k]};
            if (s1_bypass_q) begin
                y_c[k] = s1_comp_c[k];
            end else if ((&diff_c[k][DIFF_W-1:WIDTH-1]) || (~|diff_c[k][DIFF_W-1:WIDTH-1])) begin
                y_c[k] = diff_c[k][WIDTH-1:0];
            end else if (diff_c[k][DIFF_W-1]) begin
                y_c[k] = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                y_c[k] = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: output holds while the downstream stalls
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] o_tdata_q;
    logic               o_tlast_q;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
        end else if (advance_c) begin
            o_tvalid_q <= s1_valid_q;
            if (s1_valid_q) begin
                o_tdata_q <= {y_c[0], y_c[1]};
                o_tlast_q <= s1_last_q;
            end
        end
    end

    assign o_tvalid = o_tvalid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_dc_blocker_mc.sv
// Bench for dc_blocker_mc: one single-channel and one two-channel instance
// share the same stimulus. A behavioural model predicts each accepted sample
// and pushes the result to a per-instance queue; outputs are popped and
// compared as they are handed off.
module tb_dc_blocker_mc;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic        tready_a, tready_b;
    logic [31:0] od_a, od_b;
    logic        ol_a, ol_b, ov_a, ov_b;

    always #5 ce_clk = ~ce_clk;

    dc_blocker_mc #(.WIDTH(16), .NUM_CH(1), .SR_BASE(128), .SHIFT_RST(4)) dut_a (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(tready_a),
        .o_tdata(od_a), .o_tlast(ol_a), .o_tvalid(ov_a), .o_tready(o_tready)
    );

    dc_blocker_mc #(.WIDTH(16), .NUM_CH(2), .SR_BASE(128), .SHIFT_RST(4)) dut_b (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(tready_b),
        .o_tdata(od_b), .o_tlast(ol_b), .o_tvalid(ov_b), .o_tready(o_tready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint      acc_m [2][2][2];   // [instance][channel][component]
    int          ch_m  [2];
    int          shift_m;
    bit          byp_m, frz_m;
    logic [32:0] qa[$], qb[$];
    logic [32:0] last_a, last2_a, last_b, last2_b;
    logic        prev_stall_a, prev_stall_b;
    logic [32:0] prev_out_a, prev_out_b;

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [32:0] model_step(input int d, input logic [31:0] x, input logic last);
        longint xv [2];
        longint y  [2];
        longint dc;
        xv[0] = longint'($signed(x[31:16]));
        xv[1] = longint'($signed(x[15:0]));
        for (int k = 0; k < 2; k++) begin
            dc   = acc_m[d][ch_m[d]][k] >>> shift_m;
            y[k] = byp_m ? xv[k] : sat16(xv[k] - dc);
            if (!frz_m) acc_m[d][ch_m[d]][k] = acc_m[d][ch_m[d]][k] + xv[k] - dc;
        end
        if (last || (ch_m[d] + 1 >= d + 1)) ch_m[d] = 0;
        else ch_m[d] = ch_m[d] + 1;
        return {last, 16'(y[0]), 16'(y[1])};
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 2; k++) acc_m[d][c][k] = 0;
        ch_m[0] = 0; ch_m[1] = 0;
        shift_m = 4; byp_m = 1'b0; frz_m = 1'b0;
        qa.delete(); qb.delete();
    endfunction

    function automatic void model_set(input logic [7:0] addr, input logic [31:0] data);
        if (addr == 8'd128) shift_m = (data[3:0] == 4'd0) ? 1 : int'(data[3:0]);
        if (addr == 8'd129) begin
            byp_m = data[0];
            frz_m = data[1];
            if (data[2]) begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < 2; c++)
                        for (int k = 0; k < 2; k++) acc_m[d][c][k] = 0;
            end
        end
    endfunction

    // Inputs change 1 time unit after posedge, so the falling edge sees what
    // the next rising edge will act on.
    always @(negedge ce_clk) begin
        if (ce_rst) begin
            model_reset();
            prev_stall_a = 1'b0;
            prev_stall_b = 1'b0;
        end else begin
            if (prev_stall_a) check("hold_a", {ov_a, ol_a, od_a}, {1'b1, prev_out_a});
            if (prev_stall_b) check("hold_b", {ov_b, ol_b, od_b}, {1'b1, prev_out_b});
            if (ov_a && o_tready) begin
                check("out_expected_a", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) check("data_a", {ol_a, od_a}, qa.pop_front());
                last2_a = last_a;
                last_a  = {ol_a, od_a};
            end
            if (ov_b && o_tready) begin
                check("out_expected_b", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) check("data_b", {ol_b, od_b}, qb.pop_front());
                last2_b = last_b;
                last_b  = {ol_b, od_b};
            end
            prev_stall_a = ov_a && !o_tready;
            prev_stall_b = ov_b && !o_tready;
            prev_out_a   = {ol_a, od_a};
            prev_out_b   = {ol_b, od_b};
            if (i_tvalid && tready_a) begin
                check("tready_match", 64'(tready_b), 64'd1);
                qa.push_back(model_step(0, i_tdata, i_tlast));
                qb.push_back(model_step(1, i_tdata, i_tlast));
            end
            if (set_stb) model_set(set_addr, set_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_addr = a; set_data = d; set_stb = 1'b1;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int   n;
        logic ok;
        n = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        do begin
            ok = tready_a;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        check("drain_a", 64'(qa.size()), 64'd0);
        check("drain_b", 64'(qb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        ce_rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        last_a = '0; last2_a = '0; last_b = '0; last2_b = '0;
        repeat (3) tick();
        check("rst_valid_a", 64'(ov_a), 64'd0);
        check("rst_data_a",  64'(od_a), 64'd0);
        check("rst_last_a",  64'(ol_a), 64'd0);
        check("rst_valid_b", 64'(ov_b), 64'd0);
        ce_rst = 1'b0;
        tick();
        check("tready_after_rst", 64'(tready_a), 64'd1);

        // Constant I=1000, Q=-1000: first output at latency 2, then converge.
        i_tdata = 32'h03E8_FC18; i_tlast = 1'b0; i_tvalid = 1'b1;
        tick();
        check("lat1_valid", 64'(ov_a), 64'd0);
        tick();
        check("lat2_valid", 64'(ov_a), 64'd1);
        check("first_out",  64'(od_a), 64'h03E8_FC18);
        repeat (398) tick();
        drain();
        check("conv_a_400", 64'(last_a[31:0]), 64'd0);
        check("conv_b_400", 64'(last_b[31:0]), 64'd0);

        // Full negative step on a converged I channel must clamp.
        send(32'h8000_FC18, 1'b1);
        drain();
        check("sat_a", 64'(last_a[31:0]), 64'h8000_0000);

        // Two channels, 500 and -300 alternating, each converging on its own.
        write_reg(8'd129, 32'h4);
        for (int i = 0; i < 400; i++) send((i % 2 == 0) ? 32'h01F4_01F4 : 32'hFED4_FED4, 1'b0);
        drain();
        check("conv_b_ch0", 64'(last2_b[31:0]), 64'd0);
        check("conv_b_ch1", 64'(last_b[31:0]),  64'd0);
        send(32'h01F4_01F4, 1'b1);
        send(32'h01F4_01F4, 1'b0);
        drain();
        check("tlast_pass_b",  64'(last2_b[32]), 64'd1);
        check("tlast_ch0_b",   64'(last_b),      64'd0);

        // Bypass passes input through while accumulators keep running.
        write_reg(8'd129, 32'h1);
        i_tdata = 32'h1234_ABCD; i_tlast = 1'b0; i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        tick();
        check("bypass_valid", 64'(ov_a), 64'd1);
        check("bypass_a", 64'(od_a), 64'h1234_ABCD);
        check("bypass_b", 64'(od_b), 64'h1234_ABCD);
        drain();
        write_reg(8'd129, 32'h4);
        send(32'h1234_ABCD, 1'b0);
        drain();
        check("clear_a", 64'(last_a[31:0]), 64'h1234_ABCD);
        check("clear_b", 64'(last_b[31:0]), 64'h1234_ABCD);

        // Freeze, then shift written as 0.
        write_reg(8'd129, 32'h2);
        for (int i = 0; i < 6; i++) send($urandom(), 1'($urandom_range(0, 1)));
        write_reg(8'd129, 32'h0);
        write_reg(8'd128, 32'h0);
        for (int i = 0; i < 12; i++) send($urandom(), 1'b0);
        write_reg(8'd128, 32'h4);
        drain();

        // Random valid/ready traffic with a 10-cycle downstream stall.
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                i_tdata = $urandom(); i_tlast = 1'b0; i_tvalid = 1'b1; o_tready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    tick();
                    if (j >= 2) begin
                        check("stall_tready", 64'(tready_a), 64'd0);
                        check("stall_valid",  64'(ov_a),     64'd1);
                    end
                end
            end
            i_tvalid = 1'($urandom_range(0, 1));
            i_tdata  = $urandom();
            i_tlast  = ($urandom_range(0, 7) == 0);
            o_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Asynchronous reset while an output is pending.
        write_reg(8'd128, 32'h2);
        o_tready = 1'b0;
        send(32'h0101_0101, 1'b0);
        tick();
        check("pre_rst_valid", 64'(ov_a), 64'd1);
        ce_rst = 1'b1;
        #1;
        check("async_rst_valid_a", 64'(ov_a), 64'd0);
        check("async_rst_valid_b", 64'(ov_b), 64'd0);
        check("async_rst_data_a",  64'(od_a), 64'd0);
        o_tready = 1'b1;
        tick();
        ce_rst = 1'b0;
        tick();
        send(32'h03E8_FC18, 1'b1);
        send(32'h03E8_FC18, 1'b1);
        drain();
        check("post_rst_first",  64'(last2_a[31:0]), 64'h03E8_FC18);
        check("post_rst_second", 64'(last_a[31:0]),  64'h03AA_FC57);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dc_blocker_mc.md
DC_BLOCKER_MC -- requirements
Module: dc_blocker_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed bits per I/Q component; range 8..24.
REQ-002 SHALL have parameter NUM_CH, default 1: interleaved channels per packet, with per-channel DC state; range 1..16.
REQ-003 SHALL have parameter SR_BASE, default 128: settings-bus base address.
REQ-004 SHALL have parameter SHIFT_RST, default 4: reset value of the loop shift.
REQ-005 SHALL have port ce_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port ce_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port set_stb, input, 1 bit: settings write strobe.
REQ-008 SHALL have port set_addr, input, 8 bits: settings address.
REQ-009 SHALL have port set_data, input, 32 bits: settings data.
REQ-010 SHALL have port i_tdata, input, 2*WIDTH bits: input sample, I in the upper half, Q in the lower half, two's complement.
REQ-011 SHALL have ports i_tlast (input, 1), i_tvalid (input, 1) and i_tready (output, 1): AXI-stream input handshake.
REQ-012 SHALL have port o_tdata, output, 2*WIDTH bits: output sample, same packing as i_tdata.
REQ-013 SHALL have ports o_tlast (output, 1), o_tvalid (output, 1) and o_tready (input, 1): AXI-stream output handshake.

Function
REQ-014 SHALL decode two settings registers:
- SR_BASE: shift = set_data[3:0]; a written value of 0 is stored as 1.
- SR_BASE+1: ctrl; bit0 = bypass, bit1 = freeze, bit2 = clear (self-clearing pulse, not stored).
REQ-015 SHALL hold, per channel and per component, a signed accumulator acc of WIDTH+16 bits; dc = acc >>> shift (arithmetic shift).
REQ-016 SHALL, on each accepted input sample x on channel c, compute y = x - dc_c using the dc from before this sample, then update acc_c <= acc_c + x - dc_c (sign-extended, no overflow).
REQ-017 SHALL saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1] per component.
REQ-018 SHALL, when bypass=1, output y = x unchanged while accumulators still update.
REQ-019 SHALL, when freeze=1, hold all accumulators but keep subtracting the frozen dc.
REQ-020 SHALL, on a clear pulse, zero all accumulators on the next edge; if that edge also accepts a sample, clear wins and the sample's update is discarded.
REQ-021 SHALL apply shift and ctrl changes starting with the first sample accepted after the set_stb cycle.
REQ-022 SHALL keep a channel counter: it starts at 0 and increments per accepted sample, wrapping NUM_CH-1 -> 0; an accepted sample with i_tlast=1 forces it to 0 regardless of its value.
REQ-023 SHALL be a two-stage pipeline:
- Stage 1 registers x, tlast and dc, and performs the acc update.
- Stage 2 registers saturated y and tlast.
- Latency is exactly 2 cycles from acceptance to o_tvalid at full throughput.
REQ-024 SHALL compute pipeline advance = ~o_tvalid | o_tready and drive i_tready = advance; while stalled, hold all pipeline registers and accumulators.
REQ-025 SHALL sustain 1 sample/cycle; with NUM_CH=1, back-to-back samples SHALL use the correctly updated acc (no read-after-write hazard).
REQ-026 SHALL pass tlast through aligned with its sample and never drop, duplicate or reorder samples.
REQ-027 SHALL keep o_tdata and o_tlast stable while o_tvalid=1 and o_tready=0.

Reset
REQ-028 SHALL, on ce_rst=1, immediately (asynchronously) set:
- o_tvalid=0, o_tdata=0, o_tlast=0;
- all accumulators=0, channel counter=0;
- shift=SHIFT_RST, ctrl=0;
- all pipeline valids=0.
REQ-029 SHALL drive i_tready=1 from the first cycle after ce_rst deasserts; a reset mid-packet discards all in-flight samples.

Verification (WIDTH=16, shift=4 unless stated)
REQ-030 SHALL verify, with NUM_CH=1 and constant I=1000, Q=-1000: first output = (1000, -1000) two cycles after acceptance; output = (0, 0) exactly by sample 400.
REQ-031 SHALL verify, after convergence on I=1000, an input I=-32768: output I=-32768 (saturated, not -33768).
REQ-032 SHALL verify, with NUM_CH=2, alternating ch0=500 and ch1=-300 for 400 samples: both channels converge to 0 independently; a tlast after ch0 makes the next sample ch0.
REQ-033 SHALL verify random valid/ready toggling with o_tready low for 10 cycles: output sequence equals the reference model bit-exactly, with no loss and i_tready=0 during the stall.
REQ-034 SHALL verify bypass=1 on input 0x1234ABCD: o_tdata=0x1234ABCD at latency 2; then clear; then bypass=0 with the same input: first output equals the input (dc=0).
REQ-035 SHALL verify ce_rst asserted while o_tvalid=1: o_tvalid=0 in the same cycle, and readback behaviour matches the reset values (shift=4, acc=0).
